// File: rtl/branch_unit.sv
// Per-thread PC / condition-code unit: NZP capture in UPDATE, next-PC selection in EXECUTE.
// Define BRANCH_UNIT_CALL_STACK_EN to build the call/return address stack and stack_fault.
module branch_unit #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int STACK_DEPTH           = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [2:0]                       core_state,
    input  logic [2:0]                       decoded_nzp,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] decoded_immediate,
    input  logic                             decoded_nzp_write_enable,
    input  logic                             decoded_pc_mux,
    input  logic                             decoded_call,
    input  logic                             decoded_ret,
    input  logic [7:0]                       alu_out,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] next_pc,
    output logic [2:0]                       nzp,
    output logic                             stack_fault
);
    localparam int          AW         = PROGRAM_MEM_ADDR_BITS;
    localparam logic [2:0]  ST_EXECUTE = 3'b101;
    localparam logic [2:0]  ST_UPDATE  = 3'b110;

    logic [AW-1:0] next_pc_q, next_pc_d;
    logic [2:0]    nzp_q, nzp_d;
    logic [AW-1:0] pc_inc;
    logic          take_branch;
    logic          do_execute;
    logic          do_update;

    // Only the compare flags matter; upper result bits are ignored.
    logic [4:0]    unused_alu_hi;
    assign unused_alu_hi = alu_out[7:3];

    assign pc_inc      = current_pc + AW'(1);
    assign take_branch = decoded_pc_mux && (|(nzp_q & decoded_nzp));
    assign do_execute  = enable && (core_state == ST_EXECUTE);
    assign do_update   = enable && (core_state == ST_UPDATE) && decoded_nzp_write_enable;

`ifdef BRANCH_UNIT_CALL_STACK_EN
    localparam int IDXW = $clog2(STACK_DEPTH);
    localparam int SPW  = IDXW + 1;

    logic [AW-1:0]   stack_q [STACK_DEPTH];
    logic [SPW-1:0]  sp_q, sp_d;
    logic            fault_q, fault_d;
    logic            push_en;
    logic            stack_full;
    logic            stack_empty;
    logic [IDXW-1:0] top_idx;
    logic [IDXW-1:0] push_idx;
    logic [SPW-1:0]  sp_dec;

    assign stack_full  = (sp_q == SPW'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);
    assign sp_dec      = sp_q - SPW'(1);
    assign top_idx     = sp_dec[IDXW-1:0];
    assign push_idx    = sp_q[IDXW-1:0];
`else
    logic [1:0] unused_call_ret;
    localparam int stack_depth_unused = STACK_DEPTH;
    assign unused_call_ret = {decoded_call, decoded_ret};
`endif

    always_comb begin
        next_pc_d = next_pc_q;
        nzp_d     = nzp_q;
`ifdef BRANCH_UNIT_CALL_STACK_EN
        sp_d      = sp_q;
        fault_d   = fault_q;
        push_en   = 1'b0;
`endif
        // {N,Z,P} <- {lt,eq,gt}
        if (do_update)
            nzp_d = {alu_out[0], alu_out[1], alu_out[2]};

        if (do_execute) begin
            next_pc_d = take_branch ? decoded_immediate : pc_inc;
`ifdef BRANCH_UNIT_CALL_STACK_EN
            // ret outranks call; faults fall through to sequential execution.
            if (decoded_ret) begin
                if (!stack_empty) begin
                    sp_d      = sp_dec;
                    next_pc_d = stack_q[top_idx];
                end else begin
                    next_pc_d = pc_inc;
                    fault_d   = 1'b1;
                end
            end else if (decoded_call) begin
                if (!stack_full) begin
                    push_en   = 1'b1;
                    sp_d      = sp_q + SPW'(1);
                    next_pc_d = decoded_immediate;
                end else begin
                    next_pc_d = pc_inc;
                    fault_d   = 1'b1;
                end
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            next_pc_q <= '0;
            nzp_q     <= 3'b000;
`ifdef BRANCH_UNIT_CALL_STACK_EN
            sp_q      <= '0;
            fault_q   <= 1'b0;
`endif
        end else begin
            next_pc_q <= next_pc_d;
            nzp_q     <= nzp_d;
`ifdef BRANCH_UNIT_CALL_STACK_EN
            sp_q      <= sp_d;
            fault_q   <= fault_d;
`endif
        end
    end

`ifdef BRANCH_UNIT_CALL_STACK_EN
    // Stack storage needs no reset; only entries below sp are ever read.
    always_ff @(posedge clk) begin
        if (push_en && !reset)
            stack_q[push_idx] <= pc_inc;
    end

    assign stack_fault = fault_q;
`else
    assign stack_fault = 1'b0;
`endif

    assign next_pc = next_pc_q;
    assign nzp     = nzp_q;

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: reference model feeds a scoreboard queue, outputs checked after each edge.
module tb_branch_unit;
    localparam logic [2:0] EXE  = 3'b101;
    localparam logic [2:0] UPD  = 3'b110;
    localparam logic [2:0] IDLE = 3'b000;
    localparam int         DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset, enable;
    logic [2:0] core_state, decoded_nzp;
    logic [7:0] decoded_immediate, alu_out, current_pc;
    logic       decoded_nzp_write_enable, decoded_pc_mux, decoded_call, decoded_ret;
    logic [7:0] next_pc;
    logic [2:0] nzp;
    logic       stack_fault;

    branch_unit #(.PROGRAM_MEM_ADDR_BITS(8), .STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
        .decoded_nzp(decoded_nzp), .decoded_immediate(decoded_immediate),
        .decoded_nzp_write_enable(decoded_nzp_write_enable), .decoded_pc_mux(decoded_pc_mux),
        .decoded_call(decoded_call), .decoded_ret(decoded_ret), .alu_out(alu_out),
        .current_pc(current_pc), .next_pc(next_pc), .nzp(nzp), .stack_fault(stack_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] pc;
        logic [2:0] nzp;
        logic       flt;
    } exp_t;

    exp_t       sbq[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] m_pc  = 8'h00;
    logic [2:0] m_nzp = 3'b000;
    logic       m_flt = 1'b0;
    logic [7:0] m_stk[$];

    // Reference model: advance one clock with the given inputs, push expectation.
    task automatic model(input string tag, input logic rst, input logic en, input logic [2:0] st,
                         input logic [7:0] pc, input logic [7:0] imm, input logic [2:0] dn,
                         input logic mux, input logic call, input logic ret, input logic we,
                         input logic [7:0] alu);
        exp_t e;
        logic [7:0] inc;
        inc = pc + 8'd1;
        if (rst) begin
            m_pc = 8'h00; m_nzp = 3'b000; m_flt = 1'b0; m_stk.delete();
        end else if (en && st == UPD) begin
            if (we) m_nzp = {alu[0], alu[1], alu[2]};
        end else if (en && st == EXE) begin
            m_pc = (mux && ((m_nzp & dn) != 3'b000)) ? imm : inc;
`ifdef BRANCH_UNIT_CALL_STACK_EN
            if (ret) begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else begin m_pc = inc; m_flt = 1'b1; end
            end else if (call) begin
                if (m_stk.size() < DEPTH) begin m_stk.push_back(inc); m_pc = imm; end
                else begin m_pc = inc; m_flt = 1'b1; end
            end
`endif
        end
        e.tag = tag; e.pc = m_pc; e.nzp = m_nzp; e.flt = m_flt;
        sbq.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        if (sbq.size() == 0) begin
            n_cmp++; n_bad++;
            $error("FAIL sb_empty observed=none expected=entry");
            return;
        end
        e = sbq.pop_front();
        n_cmp++;
        assert (next_pc === e.pc) else begin
            n_bad++; $error("FAIL %s.next_pc observed=%h expected=%h", e.tag, next_pc, e.pc);
        end
        n_cmp++;
        assert (nzp === e.nzp) else begin
            n_bad++; $error("FAIL %s.nzp observed=%b expected=%b", e.tag, nzp, e.nzp);
        end
        n_cmp++;
        assert (stack_fault === e.flt) else begin
            n_bad++; $error("FAIL %s.fault observed=%b expected=%b", e.tag, stack_fault, e.flt);
        end
    endtask

    // Drive one clock of stimulus, then compare against the scoreboard head.
    task automatic cyc(input string tag, input logic rst, input logic en, input logic [2:0] st,
                       input logic [7:0] pc, input logic [7:0] imm, input logic [2:0] dn,
                       input logic mux, input logic call, input logic ret, input logic we,
                       input logic [7:0] alu);
        @(negedge clk);
        reset = rst; enable = en; core_state = st; current_pc = pc; decoded_immediate = imm;
        decoded_nzp = dn; decoded_pc_mux = mux; decoded_call = call; decoded_ret = ret;
        decoded_nzp_write_enable = we; alu_out = alu;
        model(tag, rst, en, st, pc, imm, dn, mux, call, ret, we, alu);
        @(posedge clk);
        #1;
        check();
    endtask

    // Plain directed check against a literal from the test plan.
    task automatic direct(input string tag, input logic [7:0] exp_pc, input logic exp_flt);
        n_cmp++;
        assert (next_pc === exp_pc && stack_fault === exp_flt) else begin
            n_bad++;
            $error("FAIL %s observed=%h/%b expected=%h/%b", tag, next_pc, stack_fault, exp_pc, exp_flt);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; core_state = IDLE; decoded_nzp = 3'b000;
        decoded_immediate = 8'h00; alu_out = 8'h00; current_pc = 8'h00;
        decoded_nzp_write_enable = 1'b0; decoded_pc_mux = 1'b0; decoded_call = 1'b0; decoded_ret = 1'b0;

        //   tag        rst en  st    pc     imm    dn      mux call ret we  alu
        cyc("reset",    1, 1, EXE,  8'h33, 8'h44, 3'b111, 1, 0, 0, 0, 8'h00);
        direct("reset_pc", 8'h00, 1'b0);
        cyc("seq",      0, 1, EXE,  8'h05, 8'h00, 3'b000, 0, 0, 0, 0, 8'h00);
        direct("seq_pc", 8'h06, 1'b0);
        cyc("cmp_gt",   0, 1, UPD,  8'h06, 8'h00, 3'b000, 0, 0, 0, 1, 8'h04);
        cyc("br_p",     0, 1, EXE,  8'h07, 8'h20, 3'b001, 1, 0, 0, 0, 8'h00);
        direct("br_taken", 8'h20, 1'b0);
        cyc("br_nz",    0, 1, EXE,  8'h20, 8'h60, 3'b110, 1, 0, 0, 0, 8'h00);
        direct("br_not_taken", 8'h21, 1'b0);
        cyc("wrap",     0, 1, EXE,  8'hFF, 8'h10, 3'b111, 0, 0, 0, 0, 8'h00);
        direct("wrap_pc", 8'h00, 1'b0);
        cyc("mask0",    0, 1, EXE,  8'h12, 8'h70, 3'b000, 1, 0, 0, 0, 8'h00);
        cyc("cmp_eq",   0, 1, UPD,  8'h13, 8'h00, 3'b000, 0, 0, 0, 1, 8'hFA);
        cyc("br_z",     0, 1, EXE,  8'h14, 8'h80, 3'b010, 1, 0, 0, 0, 8'h00);
        cyc("we_off",   0, 1, UPD,  8'h15, 8'h00, 3'b000, 0, 0, 0, 0, 8'h01);
        cyc("en0_exe",  0, 0, EXE,  8'h50, 8'h90, 3'b111, 1, 0, 0, 0, 8'h00);
        cyc("en0_upd",  0, 0, UPD,  8'h50, 8'h00, 3'b000, 0, 0, 0, 1, 8'h01);
        cyc("idle_st",  0, 1, IDLE, 8'h51, 8'h90, 3'b111, 1, 1, 0, 1, 8'h01);
        cyc("cmp_lt",   0, 1, UPD,  8'h52, 8'h00, 3'b000, 0, 0, 0, 1, 8'h01);
        cyc("br_n",     0, 1, EXE,  8'h53, 8'hA0, 3'b100, 1, 0, 0, 0, 8'h00);
        cyc("br_n_miss",0, 1, EXE,  8'hA0, 8'hB0, 3'b011, 1, 0, 0, 0, 8'h00);

`ifdef BRANCH_UNIT_CALL_STACK_EN
        cyc("call",     0, 1, EXE,  8'h10, 8'h40, 3'b000, 0, 1, 0, 0, 8'h00);
        direct("call_pc", 8'h40, 1'b0);
        cyc("ret",      0, 1, EXE,  8'h45, 8'h00, 3'b000, 0, 0, 1, 0, 8'h00);
        direct("ret_pc", 8'h11, 1'b0);
        cyc("ret_empty",0, 1, EXE,  8'h11, 8'h00, 3'b000, 0, 0, 1, 0, 8'h00);
        direct("ret_empty_pc", 8'h12, 1'b1);
        cyc("sticky",   0, 1, EXE,  8'h12, 8'h00, 3'b000, 0, 0, 0, 0, 8'h00);
        cyc("rst_clr",  1, 1, IDLE, 8'h00, 8'h00, 3'b000, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < DEPTH; i++)
            cyc("call_n", 0, 1, EXE, 8'h20 + 8'(i), 8'h60 + 8'(i), 3'b000, 0, 1, 0, 0, 8'h00);
        cyc("call_full",0, 1, EXE,  8'h30, 8'h50, 3'b000, 0, 1, 0, 0, 8'h00);
        direct("call_full_pc", 8'h31, 1'b1);
        cyc("en0_call", 0, 0, EXE,  8'h31, 8'h55, 3'b000, 0, 0, 1, 0, 8'h00);
        for (int i = DEPTH - 1; i >= 0; i--) begin
            cyc("ret_n", 0, 1, EXE, 8'h70, 8'h00, 3'b000, 0, 0, 1, 0, 8'h00);
            direct("ret_order", 8'h21 + 8'(i), 1'b1);
        end
        cyc("rst_clr2", 1, 1, IDLE, 8'h00, 8'h00, 3'b000, 0, 0, 0, 0, 8'h00);
        cyc("call_ff",  0, 1, EXE,  8'hFF, 8'h08, 3'b000, 0, 1, 0, 0, 8'h00);
        cyc("call_ret", 0, 1, EXE,  8'h08, 8'hC0, 3'b000, 0, 1, 1, 0, 8'h00);
        direct("ret_wins_wrap", 8'h00, 1'b0);
        cyc("call_b",   0, 1, EXE,  8'h02, 8'hC0, 3'b000, 0, 1, 0, 0, 8'h00);
        cyc("rst_call", 1, 1, EXE,  8'hC0, 8'hD0, 3'b000, 0, 1, 0, 0, 8'h00);
        direct("rst_call_pc", 8'h00, 1'b0);
        cyc("ret_sp0",  0, 1, EXE,  8'h00, 8'h00, 3'b000, 0, 0, 1, 0, 8'h00);
        direct("ret_sp0_pc", 8'h01, 1'b1);
`else
        cyc("call_ign", 0, 1, EXE,  8'h10, 8'h40, 3'b000, 0, 1, 0, 0, 8'h00);
        direct("call_ignored", 8'h11, 1'b0);
        cyc("ret_ign",  0, 1, EXE,  8'h11, 8'h40, 3'b000, 0, 0, 1, 0, 8'h00);
        direct("ret_ignored", 8'h12, 1'b0);
        cyc("rst_call", 1, 1, EXE,  8'hC0, 8'hD0, 3'b000, 0, 1, 0, 0, 8'h00);
        direct("rst_call_pc", 8'h00, 1'b0);
`endif

        n_cmp++;
        assert (sbq.size() == 0) else begin
            n_bad++; $error("FAIL sb_drain observed=%0d expected=0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
